// File: rtl/cva6_i2c_slave_pkg.sv
// Shared types and constants for the I2C target byte engine.
package cva6_i2c_slave_pkg;

    localparam int unsigned CNT_W   = 3;
    localparam logic [7:0]  TX_FILL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/cva6_i2c_slave_sync_edge.sv
// Synchronises SCL/SDA into clk and derives bus edges and START/STOP conditions.
module cva6_i2c_slave_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nReset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_cond_c,
    output logic stop_cond_c
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus is high, so the chain resets to 1 to avoid a spurious edge
    always_ff @(posedge clk) begin
        if (!nReset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl          = scl_sync[SYNC_STAGES-1];
    assign sda          = sda_sync[SYNC_STAGES-1];
    assign scl_rise_c   = scl & ~scl_d;
    assign scl_fall_c   = ~scl & scl_d;
    assign start_cond_c = scl & scl_d & sda_d & ~sda;
    assign stop_cond_c  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/cva6_i2c_slave_byte_ctrl.sv
// I2C target byte engine: address match, byte receive/transmit with host
// valid/ready ports and optional SCL stretching.
module cva6_i2c_slave_byte_ctrl
    import cva6_i2c_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH_EN  = 1
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       ena,
    input  logic [6:0] own_addr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       rx_nack,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rw,
    output logic       busy,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det,
    output logic       master_nack,
    output logic       rx_ovf,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_oen,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;

    cva6_i2c_slave_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .nReset      (nReset),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl         (scl_s),
        .sda         (sda_s),
        .scl_rise_c  (scl_rise),
        .scl_fall_c  (scl_fall),
        .start_cond_c(start_cond),
        .stop_cond_c (stop_cond)
    );

    assign scl_o = 1'b0;
    assign sda_o = 1'b0;

    state_t           state, state_n;
    logic [7:0]       sr, sr_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic             ack_armed, ack_armed_n;
    logic             tx_load, tx_load_n;
    logic             rx_stretch, rx_stretch_n;
    logic             tx_stretch, tx_stretch_n;
    logic             sda_val, sda_val_n;
    logic             sda_upd, sda_upd_n;
    logic             sda_oen_n, scl_oen_n;
    logic [7:0]       rx_data_n;
    logic             rx_valid_n, rw_n, busy_n, addressed_n;
    logic             tx_ready_n, start_det_n, stop_det_n, master_nack_n, rx_ovf_n;
    logic             do_load;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            ack_armed   <= 1'b0;
            tx_load     <= 1'b0;
            rx_stretch  <= 1'b0;
            tx_stretch  <= 1'b0;
            sda_val     <= 1'b1;
            sda_upd     <= 1'b0;
            sda_oen     <= 1'b1;
            scl_oen     <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rw          <= 1'b0;
            busy        <= 1'b0;
            addressed   <= 1'b0;
            tx_ready    <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            master_nack <= 1'b0;
            rx_ovf      <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            bit_cnt     <= bit_cnt_n;
            ack_armed   <= ack_armed_n;
            tx_load     <= tx_load_n;
            rx_stretch  <= rx_stretch_n;
            tx_stretch  <= tx_stretch_n;
            sda_val     <= sda_val_n;
            sda_upd     <= sda_upd_n;
            sda_oen     <= sda_oen_n;
            scl_oen     <= scl_oen_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            rw          <= rw_n;
            busy        <= busy_n;
            addressed   <= addressed_n;
            tx_ready    <= tx_ready_n;
            start_det   <= start_det_n;
            stop_det    <= stop_det_n;
            master_nack <= master_nack_n;
            rx_ovf      <= rx_ovf_n;
        end
    end

    always_comb begin
        state_n       = state;
        sr_n          = sr;
        bit_cnt_n     = bit_cnt;
        ack_armed_n   = ack_armed;
        tx_load_n     = tx_load;
        rx_stretch_n  = rx_stretch;
        tx_stretch_n  = tx_stretch;
        sda_val_n     = sda_val;
        sda_upd_n     = 1'b0;
        sda_oen_n     = sda_oen;
        scl_oen_n     = scl_oen;
        rx_data_n     = rx_data;
        rx_valid_n    = rx_valid;
        rw_n          = rw;
        busy_n        = busy;
        addressed_n   = addressed;
        tx_ready_n    = 1'b0;
        start_det_n   = 1'b0;
        stop_det_n    = 1'b0;
        master_nack_n = 1'b0;
        rx_ovf_n      = 1'b0;
        do_load       = 1'b0;

        // SDA is updated one clk after the synced SCL fall that scheduled it
        if (sda_upd) sda_oen_n = sda_val;
        if (rx_valid && rx_ready) rx_valid_n = 1'b0;

        // Stretch resolution; these handshakes complete even alongside START/STOP
        if (rx_stretch && (!rx_valid || rx_ready)) begin
            rx_data_n    = sr;
            rx_valid_n   = 1'b1;
            rx_stretch_n = 1'b0;
            scl_oen_n    = 1'b1;
        end
        if (tx_stretch && tx_valid) begin
            sr_n         = tx_data;
            tx_ready_n   = 1'b1;
            sda_oen_n    = tx_data[7];
            tx_stretch_n = 1'b0;
            scl_oen_n    = 1'b1;
        end

        if (start_cond) begin
            state_n      = ADDR;
            bit_cnt_n    = '0;
            sda_oen_n    = 1'b1;
            scl_oen_n    = 1'b1;
            rx_stretch_n = 1'b0;
            tx_stretch_n = 1'b0;
            tx_load_n    = 1'b0;
            busy_n       = 1'b1;
            addressed_n  = 1'b0;
            start_det_n  = 1'b1;
        end else if (stop_cond) begin
            state_n      = IDLE;
            sda_oen_n    = 1'b1;
            scl_oen_n    = 1'b1;
            rx_stretch_n = 1'b0;
            tx_stretch_n = 1'b0;
            tx_load_n    = 1'b0;
            busy_n       = 1'b0;
            addressed_n  = 1'b0;
            stop_det_n   = 1'b1;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sr_n      = {sr[6:0], sda_s};
                    bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_W'(7)) begin
                        if (sr[6:0] == own_addr) begin
                            rw_n        = sda_s;
                            addressed_n = 1'b1;
                            ack_armed_n = 1'b0;
                            state_n     = ADDR_ACK;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                // First fall drives the ACK, second fall ends the ACK clock
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_armed) begin
                        ack_armed_n = 1'b1;
                        sda_val_n   = 1'b0;
                        sda_upd_n   = 1'b1;
                    end else if (rw) begin
                        state_n = TX;
                        do_load = 1'b1;
                    end else begin
                        sda_val_n = 1'b1;
                        sda_upd_n = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = RX;
                    end
                end
                RX: if (scl_rise) begin
                    sr_n      = {sr[6:0], sda_s};
                    bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_W'(7)) begin
                        ack_armed_n = 1'b0;
                        state_n     = RX_ACK;
                    end
                end
                RX_ACK: if (scl_fall) begin
                    sda_upd_n = 1'b1;
                    if (!ack_armed) begin
                        ack_armed_n = 1'b1;
                        if (!rx_valid) begin
                            rx_data_n  = sr;
                            rx_valid_n = 1'b1;
                            sda_val_n  = rx_nack;
                        end else if (STRETCH_EN != 0 && !scl_s) begin
                            // ACK is set up on SDA while SCL is held low
                            rx_stretch_n = 1'b1;
                            scl_oen_n    = 1'b0;
                            sda_val_n    = rx_nack;
                        end else begin
                            sda_val_n = 1'b1;
                            rx_ovf_n  = 1'b1;
                        end
                    end else begin
                        sda_val_n = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = RX;
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (tx_load) begin
                            do_load = 1'b1;
                        end else if (bit_cnt == '0) begin
                            sda_val_n = 1'b1;
                            sda_upd_n = 1'b1;
                            state_n   = TX_ACK;
                        end else begin
                            sr_n      = {sr[6:0], 1'b0};
                            sda_val_n = sr[6];
                            sda_upd_n = 1'b1;
                        end
                    end else if (scl_rise && !tx_load) begin
                        bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                    end
                end
                TX_ACK: if (scl_rise) begin
                    if (!sda_s) begin
                        state_n   = TX;
                        tx_load_n = 1'b1;
                    end else begin
                        master_nack_n = 1'b1;
                        state_n       = IGNORE;
                    end
                end
                IDLE, IGNORE: ;
                default: state_n = IDLE;
            endcase
        end

        // Byte load at the SCL fall that enters a transmit byte
        if (do_load) begin
            bit_cnt_n = '0;
            tx_load_n = 1'b0;
            sda_upd_n = 1'b1;
            if (tx_valid) begin
                sr_n       = tx_data;
                tx_ready_n = 1'b1;
                sda_val_n  = tx_data[7];
            end else if (STRETCH_EN != 0 && !scl_s) begin
                tx_stretch_n = 1'b1;
                scl_oen_n    = 1'b0;
                sda_val_n    = 1'b1;
            end else begin
                sr_n      = TX_FILL;
                sda_val_n = TX_FILL[7];
            end
        end

        if (!ena) begin
            state_n       = IDLE;
            sr_n          = '0;
            bit_cnt_n     = '0;
            ack_armed_n   = 1'b0;
            tx_load_n     = 1'b0;
            rx_stretch_n  = 1'b0;
            tx_stretch_n  = 1'b0;
            sda_val_n     = 1'b1;
            sda_upd_n     = 1'b0;
            sda_oen_n     = 1'b1;
            scl_oen_n     = 1'b1;
            rx_data_n     = '0;
            rx_valid_n    = 1'b0;
            rw_n          = 1'b0;
            busy_n        = 1'b0;
            addressed_n   = 1'b0;
            tx_ready_n    = 1'b0;
            start_det_n   = 1'b0;
            stop_det_n    = 1'b0;
            master_nack_n = 1'b0;
            rx_ovf_n      = 1'b0;
        end
    end

endmodule
